// File: rtl/score_display.sv
// Score keeper and 3-digit multiplexed 7-segment driver for the snake game.
// Optional high-score tracking is built when SCORE_HIGHSCORE_EN is defined.
module score_display #(
    parameter int unsigned REFRESH_CYCLES = 4096,
    parameter int unsigned FLASH_CYCLES   = 6000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_restart,
    input  logic        i_eat,
    input  logic        i_failure,
    input  logic        i_success,
    output logic [11:0] o_score,
    output logic [11:0] o_high_score,
    output logic        o_new_high,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [2:0]  o_digit_sel
);

    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned FW = $clog2(2 * FLASH_CYCLES);

    typedef enum logic [1:0] {PLAY, OVER_FAIL, OVER_WIN} state_t;

    state_t        state, state_n;
    logic          eat_q, eat_q_n, eat_ev;
    logic [11:0]   score_n;
    logic [RW-1:0] refresh_cnt, refresh_n;
    logic [1:0]    digit, digit_n;
    logic [FW-1:0] flash_cnt, flash_n;
    logic [3:0]    nib;
    logic          blank, flash_hi;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [2:0]    sel_n;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign eat_ev = i_eat && !eat_q;

    // Next-state for game FSM, score, refresh/flash counters and display outputs.
    always_comb begin
        state_n   = state;
        score_n   = o_score;
        eat_q_n   = i_eat;
        refresh_n = refresh_cnt + RW'(1);
        digit_n   = digit;
        flash_n   = '0;
        nib       = 4'd0;
        blank     = 1'b0;

        case (state)
            PLAY: begin
                if (i_failure)      state_n = OVER_FAIL;
                else if (i_success) state_n = OVER_WIN;
            end
            default: state_n = state;
        endcase

        // BCD increment with carry, saturating at 999; counts on the exit edge too.
        if (state == PLAY && eat_ev && o_score != 12'h999) begin
            if (o_score[3:0] != 4'd9) begin
                score_n[3:0] = o_score[3:0] + 4'd1;
            end else begin
                score_n[3:0] = 4'd0;
                if (o_score[7:4] != 4'd9) begin
                    score_n[7:4] = o_score[7:4] + 4'd1;
                end else begin
                    score_n[7:4]  = 4'd0;
                    score_n[11:8] = o_score[11:8] + 4'd1;
                end
            end
        end

        if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
            refresh_n = '0;
            digit_n   = (digit == 2'd2) ? 2'd0 : digit + 2'd1;
        end

        // Flash counter sits at 0 during play, so it starts from 0 on entry.
        if (state != PLAY) begin
            flash_n = (flash_cnt == FW'(2 * FLASH_CYCLES - 1)) ? '0 : flash_cnt + FW'(1);
        end

        if (i_restart) begin
            state_n   = PLAY;
            score_n   = '0;
            eat_q_n   = 1'b0;
            refresh_n = '0;
            digit_n   = 2'd0;
            flash_n   = '0;
        end

        // Display outputs follow the next-state values so they align with the counters.
        case (digit_n)
            2'd0:    begin nib = score_n[3:0];  blank = 1'b0;                   end
            2'd1:    begin nib = score_n[7:4];  blank = (score_n[11:4] == 8'h00); end
            default: begin nib = score_n[11:8]; blank = (score_n[11:8] == 4'h0);  end
        endcase
        flash_hi = (flash_n >= FW'(FLASH_CYCLES));
        seg_n    = blank ? 7'h00 : seg_code(nib);
        if (state_n != PLAY && flash_hi) seg_n = 7'h00;
        dp_n  = (state_n == OVER_WIN) && !flash_hi;
        sel_n = 3'(3'b001 << digit_n);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PLAY;
            o_score     <= '0;
            eat_q       <= 1'b0;
            refresh_cnt <= '0;
            digit       <= 2'd0;
            flash_cnt   <= '0;
            o_seg       <= 7'h3F;
            o_dp        <= 1'b0;
            o_digit_sel <= 3'b001;
        end else begin
            state       <= state_n;
            o_score     <= score_n;
            eat_q       <= eat_q_n;
            refresh_cnt <= refresh_n;
            digit       <= digit_n;
            flash_cnt   <= flash_n;
            o_seg       <= seg_n;
            o_dp        <= dp_n;
            o_digit_sel <= sel_n;
        end
    end

`ifdef SCORE_HIGHSCORE_EN
    logic        end_q;
    logic [11:0] high_q;
    logic        new_high_q;

    // High score is compared one edge after the game ends, using the final score.
    always_ff @(posedge clk) begin
        if (rst) begin
            end_q      <= 1'b0;
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            end_q <= !i_restart && (state == PLAY) && (state_n != PLAY);
            if (i_restart) begin
                new_high_q <= 1'b0;
            end else if (end_q && (o_score > high_q)) begin
                high_q     <= o_score;
                new_high_q <= 1'b1;
            end
        end
    end

    assign o_high_score = high_q;
    assign o_new_high   = new_high_q;
`else
    assign o_high_score = 12'h000;
    assign o_new_high   = 1'b0;
`endif

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display (small refresh/flash periods).
module tb_score_display;

    localparam int unsigned REF = 4;
    localparam int unsigned FL  = 8;
`ifdef SCORE_HIGHSCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_restart = 1'b0;
    logic        i_eat = 1'b0;
    logic        i_failure = 1'b0;
    logic        i_success = 1'b0;
    logic [11:0] o_score, o_high_score;
    logic        o_new_high;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [2:0]  o_digit_sel;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    score_display #(.REFRESH_CYCLES(REF), .FLASH_CYCLES(FL)) dut (
        .clk(clk), .rst(rst), .i_restart(i_restart), .i_eat(i_eat),
        .i_failure(i_failure), .i_success(i_success), .o_score(o_score),
        .o_high_score(o_high_score), .o_new_high(o_new_high), .o_seg(o_seg),
        .o_dp(o_dp), .o_digit_sel(o_digit_sel)
    );

    always #5 clk = ~clk;

    // Edge counter since the last reset/restart edge models the digit multiplexer.
    task automatic tick();
        @(posedge clk);
        if (rst || i_restart) cyc = 0;
        else cyc++;
        #1;
    endtask

    task automatic pulse(input int w);
        i_eat = 1'b1;
        repeat (w) tick();
        i_eat = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int cur_digit();
        return (cyc / REF) % 3;
    endfunction

    function automatic logic [2:0] exp_sel(input int d);
        logic [2:0] one;
        one = 3'b001;
        return one << d;
    endfunction

    function automatic logic [6:0] code(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B;
            4'd3: return 7'h4F; 4'd4: return 7'h66; 4'd5: return 7'h6D;
            4'd6: return 7'h7D; 4'd7: return 7'h07; 4'd8: return 7'h7F;
            4'd9: return 7'h6F; default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] s, input int d);
        if (d == 0) return code(s[3:0]);
        if (d == 1) return (s[11:4] == 8'h00) ? 7'h00 : code(s[7:4]);
        return (s[11:8] == 4'h0) ? 7'h00 : code(s[11:8]);
    endfunction

    task automatic test_reset();
        do_reset();
        tests++;
        if (o_score !== 12'h000 || o_high_score !== 12'h000 || o_new_high !== 1'b0) begin
            fails++;
            $display("FAIL reset_score: got score=%h high=%h new=%b want 000 000 0", o_score, o_high_score, o_new_high);
        end
        tests++;
        if (o_digit_sel !== 3'b001 || o_seg !== 7'h3F || o_dp !== 1'b0) begin
            fails++;
            $display("FAIL reset_display: got sel=%b seg=%h dp=%b want 001 3f 0", o_digit_sel, o_seg, o_dp);
        end
        repeat (3) tick();
        tests++;
        if (o_digit_sel !== 3'b001) begin
            fails++;
            $display("FAIL refresh_hold: got sel=%b want 001", o_digit_sel);
        end
        tick();
        tests++;
        if (o_digit_sel !== 3'b010 || o_seg !== 7'h00) begin
            fails++;
            $display("FAIL refresh_advance: got sel=%b seg=%h want 010 00", o_digit_sel, o_seg);
        end
    endtask

    task automatic test_count();
        do_reset();
        i_eat = 1'b1;
        tick();
        tests++;
        if (o_score !== 12'h001) begin
            fails++;
            $display("FAIL eat_latency: got %h want 001", o_score);
        end
        repeat (4) tick();
        i_eat = 1'b0;
        tick();
        tests++;
        if (o_score !== 12'h001) begin
            fails++;
            $display("FAIL eat_held_once: got %h want 001", o_score);
        end
        pulse(5);
        pulse(5);
        tests++;
        if (o_score !== 12'h003) begin
            fails++;
            $display("FAIL eat_three: got %h want 003", o_score);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (998) pulse(1);
        tests++;
        if (o_score !== 12'h998) begin
            fails++;
            $display("FAIL preload_998: got %h want 998", o_score);
        end
        pulse(1);
        pulse(1);
        tests++;
        if (o_score !== 12'h999) begin
            fails++;
            $display("FAIL reach_999: got %h want 999", o_score);
        end
        pulse(1);
        tests++;
        if (o_score !== 12'h999) begin
            fails++;
            $display("FAIL saturate_999: got %h want 999", o_score);
        end
    endtask

    task automatic test_blank();
        int bad;
        do_reset();
        repeat (7) pulse(1);
        bad = 0;
        for (int k = 0; k < 3 * REF + 2; k++) begin
            if (o_digit_sel !== exp_sel(cur_digit()) || o_seg !== exp_seg(12'h007, cur_digit())) begin
                bad++;
                $display("FAIL blank_007: cyc=%0d got sel=%b seg=%h want sel=%b seg=%h", cyc,
                         o_digit_sel, o_seg, exp_sel(cur_digit()), exp_seg(12'h007, cur_digit()));
            end
            tick();
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    task automatic test_fail_blink();
        logic [6:0] e;
        do_reset();
        repeat (42) pulse(1);
        i_eat = 1'b1;
        i_failure = 1'b1;
        tick();
        i_eat = 1'b0;
        tests++;
        if (o_score !== 12'h043) begin
            fails++;
            $display("FAIL fail_same_edge: got %h want 043", o_score);
        end
        for (int k = 0; k <= 2 * FL; k++) begin
            if (k != 0) tick();
            e = ((k % (2 * FL)) >= FL) ? 7'h00 : exp_seg(12'h043, cur_digit());
            tests++;
            if (o_seg !== e || o_dp !== 1'b0 || o_digit_sel !== exp_sel(cur_digit())) begin
                fails++;
                $display("FAIL fail_blink k=%0d: got seg=%h dp=%b sel=%b want seg=%h dp=0 sel=%b",
                         k, o_seg, o_dp, o_digit_sel, e, exp_sel(cur_digit()));
            end
        end
        repeat (FL + 3) tick();
        pulse(2);
        tests++;
        if (o_score !== 12'h043) begin
            fails++;
            $display("FAIL fail_no_count: got %h want 043", o_score);
        end
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        i_failure = 1'b0;
        tests++;
        if (o_score !== 12'h000 || o_seg !== 7'h3F || o_digit_sel !== 3'b001 || o_dp !== 1'b0) begin
            fails++;
            $display("FAIL restart_mid_blink: got score=%h seg=%h sel=%b dp=%b want 000 3f 001 0",
                     o_score, o_seg, o_digit_sel, o_dp);
        end
    endtask

    task automatic test_high_score();
        do_reset();
        repeat (12) pulse(1);
        i_failure = 1'b1;
        tick();
        i_failure = 1'b0;
        repeat (2) tick();
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        tests++;
        if (o_high_score !== (HS ? 12'h012 : 12'h000) || o_new_high !== 1'b0 || o_score !== 12'h000) begin
            fails++;
            $display("FAIL game1_high: got high=%h new=%b score=%h want high=%h new=0 score=000",
                     o_high_score, o_new_high, o_score, HS ? 12'h012 : 12'h000);
        end
        repeat (5) pulse(1);
        i_success = 1'b1;
        tick();
        tests++;
        if (o_dp !== 1'b1 || o_seg !== exp_seg(12'h005, cur_digit())) begin
            fails++;
            $display("FAIL win_visible: got dp=%b seg=%h want dp=1 seg=%h", o_dp, o_seg, exp_seg(12'h005, cur_digit()));
        end
        repeat (FL) tick();
        tests++;
        if (o_dp !== 1'b0 || o_seg !== 7'h00) begin
            fails++;
            $display("FAIL win_dark: got dp=%b seg=%h want dp=0 seg=00", o_dp, o_seg);
        end
        tests++;
        if (o_high_score !== (HS ? 12'h012 : 12'h000) || o_new_high !== 1'b0) begin
            fails++;
            $display("FAIL game2_high: got high=%h new=%b want high=%h new=0", o_high_score, o_new_high, HS ? 12'h012 : 12'h000);
        end
        i_success = 1'b0;
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        repeat (20) pulse(1);
        i_failure = 1'b1;
        tick();
        tests++;
        if (o_high_score !== (HS ? 12'h012 : 12'h000)) begin
            fails++;
            $display("FAIL game3_high_before: got %h want %h", o_high_score, HS ? 12'h012 : 12'h000);
        end
        tick();
        i_failure = 1'b0;
        tests++;
        if (o_high_score !== (HS ? 12'h020 : 12'h000) || o_new_high !== HS) begin
            fails++;
            $display("FAIL game3_high: got high=%h new=%b want high=%h new=%b", o_high_score, o_new_high, HS ? 12'h020 : 12'h000, HS);
        end
    endtask

    task automatic test_restart_eat();
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        repeat (10) pulse(1);
        tests++;
        if (o_score !== 12'h010) begin
            fails++;
            $display("FAIL score_010: got %h want 010", o_score);
        end
        i_restart = 1'b1;
        i_eat = 1'b1;
        tick();
        i_restart = 1'b0;
        i_eat = 1'b0;
        tests++;
        if (o_score !== 12'h000 || o_seg !== 7'h3F || o_digit_sel !== 3'b001) begin
            fails++;
            $display("FAIL restart_eat: got score=%h seg=%h sel=%b want 000 3f 001", o_score, o_seg, o_digit_sel);
        end
        tick();
        pulse(1);
        tests++;
        if (o_score !== 12'h001) begin
            fails++;
            $display("FAIL play_after_restart: got %h want 001", o_score);
        end
        do_reset();
        tests++;
        if (o_high_score !== 12'h000 || o_new_high !== 1'b0 || o_score !== 12'h000) begin
            fails++;
            $display("FAIL rst_clears_high: got high=%h new=%b score=%h want 000 0 000", o_high_score, o_new_high, o_score);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_saturate();
        test_blank();
        test_fail_blink();
        test_high_score();
        test_restart_eat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
